seq_divider: RTL and testbench
==============================

# seq_divider

Sequential restoring divider: the inverse of the array multiplier in the same Actel-cell datapath. Takes an unsigned N-bit dividend and divisor on a start pulse and iterates one quotient bit per clock. After N iterations it presents the quotient and remainder with a one-cycle done pulse. Sits beside the multiplier in the arithmetic datapath and shares its start/done control style.

## Interface
- N, 8: operand, quotient and remainder width. Iteration counter is 4 bits, so N ≤ 16.
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset (drives clr of every s2 flop).
- start, in, 1: request; sampled only in IDLE.
- dividend, in, N: unsigned; captured on the accepting edge.
- divisor, in, N: unsigned; captured on the accepting edge.
- busy, out, 1: high while iterating (CALC).
- done, out, 1: one-cycle pulse; results valid.
- quotient, out, N: unsigned quotient; held until the next accepted start.
- remainder, out, N: unsigned remainder; held until the next accepted start.
- div_by_zero, out, 1: captured divisor was 0; held with the results.

## Operation
- Registers:
  - R: partial remainder, N+1 bits.
  - Q: dividend/quotient shift register, N bits.
  - D: divisor, N bits.
  - 4-bit iteration counter with init/inc.
  - 2-bit state.
- FSM states: IDLE=00, CALC=01, DONE=10.
  - IDLE→CALC on start. On that edge: R=0, Q=dividend, D=divisor, counter=0, div_by_zero=(divisor==0).
  - CALC: each edge performs one step and increments the counter. When the counter reads N-1, that edge performs the final step and goes to DONE.
  - DONE→IDLE unconditionally on the next edge.
- Step (combinational, then registered):
  - S = {R[N-1:0], Q[N-1]}.
  - T = S − {0,D} in N+1 bits.
  - If there is no borrow: R=T and Q={Q[N-2:0],1}.
  - Otherwise: R=S and Q={Q[N-2:0],0}.
- Outputs: quotient=Q, remainder=R[N-1:0]. R[N] is always 0 after a step because R < D.
- Divide by zero needs no special path: the algorithm yields quotient=all ones and remainder=dividend. div_by_zero flags this case.
- start while in CALC or DONE is ignored; no queueing.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Reset is honoured mid-operation, asynchronously. The bench sees all outputs at 0 immediately, and the next start is accepted normally.
- Latency, with start accepted at edge k:
  - busy=1 from edge k to edge k+N.
  - done=1 from edge k+N to edge k+N+1.
  - busy and done are never high together.
- Earliest next accept is edge k+N+2, the first IDLE edge.
- Throughput: one division per N+2 cycles.
- Results change only at step edges; they are stable and valid while done=1 and thereafter until the next accept.
- The critical path is the N+1-bit ripple borrow chain of FA cells plus the result mux. No combinational path from any input to any output.

## Structure
- Shared package (arith_pkg):
  - default N;
  - state encodings IDLE/CALC/DONE;
  - counter width (4).
- One sub-module, div_step: purely combinational N+1-bit trial subtract (FA/NOT cells, borrow out) plus the restore mux (c1 cells).
  - Inputs: S, D.
  - Outputs: next R, quotient bit.
- Top level holds:
  - R/Q/D as s2 load/shift registers;
  - the iteration counter, counter16-style;
  - the FSM flops and decode.

## Test plan
- 100/7 → quotient=14, remainder=2, div_by_zero=0. done exactly N=8 cycles after the accept edge; busy high 8 cycles.
- 255/1 → 255, 0. 5/9 → 0, 5. 200/200 → 1, 0. 255/255 → 1, 0.
- 77/0 → quotient=255, remainder=77, div_by_zero=1. The flag clears on the next accepted non-zero division.
- start held high continuously through CALC and DONE → only one operation in flight. The second accept occurs at edge k+10, with operands sampled at that edge.
- Assert rst mid-CALC at iteration 4 → all outputs read 0 before the next edge, state IDLE. A following 100/7 completes correctly (14, 2).
- Randomised sweep against a reference model: 1000 random pairs including 0 and 255 extremes. Every result matches integer / and %, and latency is always N.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants and FSM encoding for the sequential restoring divider.
package seq_divider_pkg;

    // Default operand width; the 4-bit iteration counter limits this to 16.
    localparam int DEFAULT_N = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done request bus between a divider client (master) and the divider (slave).
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) ();

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division step: N+1-bit ripple trial subtract plus restore mux.
module seq_divider_step
    import seq_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N:0]   s_i,   // shifted partial remainder {R, next dividend bit}
    input  logic [N-1:0] d_i,   // divisor
    output logic [N-1:0] r_o,   // next partial remainder (MSB is always zero, not kept)
    output logic         q_o    // quotient bit: 1 when the subtract did not borrow
);

    logic [N:0]   d_ext;
    logic [N+1:0] bw;
    logic [N-1:0] t;

    // Ripple borrow chain across all N+1 bits, then the low N difference bits.
    always_comb begin
        d_ext = {1'b0, d_i};
        bw    = '0;
        t     = '0;
        for (int i = 0; i <= N; i++) begin
            bw[i+1] = (~s_i[i] & d_ext[i]) | (~(s_i[i] ^ d_ext[i]) & bw[i]);
        end
        for (int i = 0; i < N; i++) begin
            t[i] = s_i[i] ^ d_ext[i] ^ bw[i];
        end
    end

    // No borrow keeps the difference; a borrow restores the shifted remainder.
    assign q_o = ~bw[N+1];
    assign r_o = bw[N+1] ? s_i[N-1:0] : t;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, done pulse after N steps.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       r_q, r_d;
    logic [N-1:0]       q_q, q_d;
    logic [N-1:0]       d_q, d_d;
    logic               dbz_q, dbz_d;

    logic [N-1:0]       step_r;
    logic               step_q;

    seq_divider_step #(.N(N)) u_step (
        .s_i ({r_q, q_q[N-1]}),
        .d_i (d_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    // Next-state decode: load on accept, shift/step while calculating, then report.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    r_d     = '0;
                    q_d     = bus.dividend;
                    d_d     = bus.divisor;
                    dbz_d   = (bus.divisor == '0);
                end
            end
            CALC: begin
                r_d   = step_r;
                q_d   = {q_q[N-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N-1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == CALC);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = q_q;
    assign bus.remainder   = r_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and swept bench for seq_divider (N = 8).
module tb_seq_divider;

    localparam int N = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one division from IDLE; returns results at the done cycle, the number
    // of edges from accept to done, the cycles busy was seen high, and whether
    // busy and done were ever high together. Leaves the DUT back in IDLE.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [N-1:0] q, output logic [N-1:0] r,
                           output logic z, output int lat, output int bcyc,
                           output logic overlap);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = N'($urandom);
        lat     = 0;
        bcyc    = 0;
        overlap = 1'b0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.busy && bus.done) overlap = 1'b1;
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #3;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b q=%0d r=%0d, want idle zeros",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] q, r;
        logic         z, ov;
        int           lat, bc;
        run_div(8'd100, 8'd7, q, r, z, lat, bc, ov);
        checks++;
        if (q !== 8'd14 || r !== 8'd2 || z !== 1'b0) begin
            errors++;
            $display("FAIL basic_100_7: got q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0", q, r, z);
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want 8", lat);
        end
        checks++;
        if (bc !== 8 || ov !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got busy cycles=%0d overlap=%b, want 8 and 0", bc, ov);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin
            errors++;
            $display("FAIL basic_hold: got done=%b busy=%b q=%0d r=%0d, want 0 0 14 2",
                     bus.done, bus.busy, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_vectors();
        logic [N-1:0] va [4] = '{8'd255, 8'd5, 8'd200, 8'd255};
        logic [N-1:0] vb [4] = '{8'd1,   8'd9, 8'd200, 8'd255};
        logic [N-1:0] vq [4] = '{8'd255, 8'd0, 8'd1,   8'd1};
        logic [N-1:0] vr [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
        logic [N-1:0] q, r;
        logic         z, ov;
        int           lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], q, r, z, lat, bc, ov);
            checks++;
            if (q !== vq[i] || r !== vr[i] || z !== 1'b0 || lat !== 8) begin
                errors++;
                $display("FAIL vector_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=0 lat=8",
                         va[i], vb[i], q, r, z, lat, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [N-1:0] q, r;
        logic         z, ov;
        int           lat, bc;
        run_div(8'd77, 8'd0, q, r, z, lat, bc, ov);
        checks++;
        if (q !== 8'd255 || r !== 8'd77 || z !== 1'b1 || lat !== 8) begin
            errors++;
            $display("FAIL div_zero: got q=%0d r=%0d dbz=%b lat=%0d, want q=255 r=77 dbz=1 lat=8",
                     q, r, z, lat);
        end
        checks++;
        if (bus.div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_zero_hold: got dbz=%b, want 1", bus.div_by_zero);
        end
        run_div(8'd10, 8'd3, q, r, z, lat, bc, ov);
        checks++;
        if (q !== 8'd3 || r !== 8'd1 || z !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_clear: got q=%0d r=%0d dbz=%b, want q=3 r=1 dbz=0", q, r, z);
        end
    endtask

    task automatic test_start_held();
        int edges;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd6;
        @(posedge clk); #1;
        bus.dividend = 8'd90;
        bus.divisor  = 8'd9;
        edges = 0;
        while (!bus.done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if (edges !== 8 || bus.quotient !== 8'd8 || bus.remainder !== 8'd2) begin
            errors++;
            $display("FAIL held_first: got lat=%0d q=%0d r=%0d, want lat=8 q=8 r=2",
                     edges, bus.quotient, bus.remainder);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL held_gap: got busy=%b done=%b at k+9, want 0 0", bus.busy, bus.done);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL held_reaccept: got busy=%b at k+10, want 1", bus.busy);
        end
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 8'd0;
        edges = 0;
        while (!bus.done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if (edges !== 8 || bus.quotient !== 8'd10 || bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL held_second: got lat=%0d q=%0d r=%0d dbz=%b, want lat=8 q=10 r=0 dbz=0",
                     edges, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] q, r;
        logic         z, ov;
        int           lat, bc;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        run_div(8'd100, 8'd7, q, r, z, lat, bc, ov);
        checks++;
        if (q !== 8'd14 || r !== 8'd2 || z !== 1'b0 || lat !== 8) begin
            errors++;
            $display("FAIL reset_mid_recover: got q=%0d r=%0d dbz=%b lat=%0d, want 14 2 0 8",
                     q, r, z, lat);
        end
    endtask

    task automatic test_sweep();
        logic [N-1:0] a, b, q, r, eq, er;
        logic         z, ez, ov;
        int           lat, bc;
        logic [N-1:0] ea [6] = '{8'd0, 8'd0,   8'd255, 8'd255, 8'd0, 8'd1};
        logic [N-1:0] eb [6] = '{8'd0, 8'd255, 8'd0,   8'd255, 8'd1, 8'd255};
        for (int i = 0; i < 1000; i++) begin
            if (i < 6) begin
                a = ea[i];
                b = eb[i];
            end else begin
                case ($urandom_range(0, 7))
                    0:       a = 8'd0;
                    1:       a = 8'd255;
                    default: a = N'($urandom);
                endcase
                case ($urandom_range(0, 7))
                    0:       b = 8'd0;
                    1:       b = 8'd255;
                    default: b = N'($urandom);
                endcase
            end
            if (b == 0) begin
                eq = 8'd255;
                er = a;
                ez = 1'b1;
            end else begin
                eq = a / b;
                er = a % b;
                ez = 1'b0;
            end
            run_div(a, b, q, r, z, lat, bc, ov);
            checks++;
            if (q !== eq || r !== er || z !== ez || lat !== 8 || bc !== 8 || ov !== 1'b0) begin
                errors++;
                $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d busy=%0d ov=%b, want q=%0d r=%0d dbz=%b lat=8 busy=8 ov=0",
                         a, b, q, r, z, lat, bc, ov, eq, er, ez);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_start_held();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
